// File: rtl/uart_tx_param_if.sv
// Input handshake bundle for uart_tx_param.
// The producer (register bank or DMA) drives the master side and the transmitter is the slave.
interface uart_tx_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter.
// Sends DATA_W-bit words LSB-first: start bit, data bits, optional parity bit, then one or two stop bits.
// Bit timing follows the external baud_tick strobe, and a frame starts only on a tick.
// parity_mode and stop2 are captured together with each accepted word.
// Build option UART_TX_FIFO_EN replaces the single holding register with a FIFO_DEPTH-entry FIFO.
// Reset is synchronous and active-low.
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  uart_tx_param_if.slave       in_if,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 tx,
  output logic                 busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // Stop elaboration when the parameters are outside the supported range.
  if (DATA_W < 5 || DATA_W > 9 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badParam
    $error("uart_tx_param: DATA_W must be 5..9 and FIFO_DEPTH a power of two in 2..16");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               parEn_q, parEn_d;
  logic               parBit_q, parBit_d;
  logic               twoStop_q, twoStop_d;

  // Head of the pending-word storage: the holding register or the FIFO head.
  logic               pendValid;
  logic [DATA_W-1:0]  pendData;
  logic [1:0]         pendMode;
  logic               pendStop2;

  logic               loadWord;
  logic               accept;

  assign accept = in_if.in_valid && in_if.in_ready;

`ifdef UART_TX_FIFO_EN

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] fifoData_q  [FIFO_DEPTH];
  logic [1:0]        fifoMode_q  [FIFO_DEPTH];
  logic              fifoStop2_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              fifoFull;

  assign fifoFull       = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign in_if.in_ready = reset && !fifoFull;

  assign pendValid = (count_q != '0);
  assign pendData  = fifoData_q[rdPtr_q];
  assign pendMode  = fifoMode_q[rdPtr_q];
  assign pendStop2 = fifoStop2_q[rdPtr_q];

  // FIFO pointer and occupancy update: push on accept, pop when the shifter loads.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (accept) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (loadWord) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({accept, loadWord})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage holds the word together with its frame configuration.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifoData_q[wrPtr_q]  <= in_if.in_data;
      fifoMode_q[wrPtr_q]  <= parity_mode;
      fifoStop2_q[wrPtr_q] <= stop2;
    end
  end

`else

  logic              holdFull_q, holdFull_d;
  logic [DATA_W-1:0] holdData_q, holdData_d;
  logic [1:0]        holdMode_q, holdMode_d;
  logic              holdStop2_q, holdStop2_d;

  assign in_if.in_ready = reset && !holdFull_q;

  assign pendValid = holdFull_q;
  assign pendData  = holdData_q;
  assign pendMode  = holdMode_q;
  assign pendStop2 = holdStop2_q;

  // Holding register: a load empties it, and an accept can only happen while it is already empty.
  always_comb begin
    holdFull_d  = holdFull_q;
    holdData_d  = holdData_q;
    holdMode_d  = holdMode_q;
    holdStop2_d = holdStop2_q;
    if (loadWord) begin
      holdFull_d = 1'b0;
    end else if (accept) begin
      holdFull_d  = 1'b1;
      holdData_d  = in_if.in_data;
      holdMode_d  = parity_mode;
      holdStop2_d = stop2;
    end
  end

  // Holding register state; reset empties it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      holdFull_q  <= 1'b0;
      holdData_q  <= '0;
      holdMode_q  <= 2'b00;
      holdStop2_q <= 1'b0;
    end else begin
      holdFull_q  <= holdFull_d;
      holdData_q  <= holdData_d;
      holdMode_q  <= holdMode_d;
      holdStop2_q <= holdStop2_d;
    end
  end

`endif

  // Frame sequencer: every transition and every tx change happens only on a baud tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    parEn_d   = parEn_q;
    parBit_d  = parBit_q;
    twoStop_d = twoStop_q;
    loadWord  = 1'b0;

    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (pendValid) begin
            loadWord = 1'b1;
            tx_d     = 1'b0;
            state_d  = START;
          end
        end
        START: begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
          state_d = DATA;
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            if (parEn_q) begin
              tx_d    = parBit_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP1;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          tx_d    = 1'b1;
          state_d = STOP1;
        end
        STOP1: begin
          if (twoStop_q) begin
            tx_d    = 1'b1;
            state_d = STOP2;
          end else if (pendValid) begin
            loadWord = 1'b1;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
        STOP2: begin
          if (pendValid) begin
            loadWord = 1'b1;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    if (loadWord) begin
      shift_d   = pendData;
      parEn_d   = (pendMode == 2'b01) || (pendMode == 2'b10);
      parBit_d  = (pendMode == 2'b01) ? (^pendData) : (~^pendData);
      twoStop_d = pendStop2;
    end
  end

  // Sequencer registers; reset abandons any frame and drives the line idle high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      parEn_q   <= 1'b0;
      parBit_q  <= 1'b0;
      twoStop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      parEn_q   <= parEn_d;
      parBit_q  <= parBit_d;
      twoStop_q <= twoStop_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE) || pendValid;

endmodule
